// File: rtl/eqn_cmp_stream_if.sv
// Stream-side bundle for eqn_cmp_stream: operand handshake in, flag handshake out.
// The master is the producer/consumer environment; the slave is the comparator.
interface eqn_cmp_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             aeqb;
    logic             altb;
    logic             agtb;

    modport master (
        output a,
        output b,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  aeqb,
        input  altb,
        input  agtb
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output aeqb,
        output altb,
        output agtb
    );
endinterface

// File: rtl/eqn_cmp_stream.sv
// Registered streaming magnitude comparator with saturating match/mismatch statistics
// and first-mismatch index capture; single-entry output register, no skid buffer.
module eqn_cmp_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SIGNED    = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    eqn_cmp_stream_if.slave      s,
    output logic [CNT_WIDTH-1:0] match_cnt,
    output logic [CNT_WIDTH-1:0] mismatch_cnt,
    output logic [CNT_WIDTH-1:0] first_mis_idx,
    output logic                 first_mis_valid
);

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CntZero = '0;
    localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0] state_q, state_d;
    logic       aeqb_q, aeqb_d;
    logic       altb_q, altb_d;
    logic       agtb_q, agtb_d;

    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] match_q, match_d;
    logic [CNT_WIDTH-1:0] mis_q, mis_d;
    logic [CNT_WIDTH-1:0] fidx_q, fidx_d;
    logic                 fvalid_q, fvalid_d;

    logic out_valid;
    logic in_ready;
    logic accept;
    logic cmp_eq;
    logic cmp_lt;
    logic cmp_gt;

    // Clear is applied before a same-cycle accept, so accept updates build on these.
    logic [CNT_WIDTH-1:0] idx_base;
    logic [CNT_WIDTH-1:0] match_base;
    logic [CNT_WIDTH-1:0] mis_base;
    logic [CNT_WIDTH-1:0] fidx_base;
    logic                 fvalid_base;

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || s.out_ready;
    assign accept    = s.in_valid && in_ready;

    always_comb begin
        cmp_eq = (s.a == s.b);
        if (SIGNED != 0) begin
            cmp_lt = ($signed(s.a) < $signed(s.b));
        end else begin
            cmp_lt = (s.a < s.b);
        end
        cmp_gt = !cmp_eq && !cmp_lt;
    end

    always_comb begin
        state_d = state_q;
        aeqb_d  = aeqb_q;
        altb_d  = altb_q;
        agtb_d  = agtb_q;
        if (accept) begin
            state_d = StFull;
            aeqb_d  = cmp_eq;
            altb_d  = cmp_lt;
            agtb_d  = cmp_gt;
        end else if (s.out_ready) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        idx_base    = clear ? CntZero : idx_q;
        match_base  = clear ? CntZero : match_q;
        mis_base    = clear ? CntZero : mis_q;
        fidx_base   = clear ? CntZero : fidx_q;
        fvalid_base = clear ? 1'b0 : fvalid_q;

        idx_d    = idx_base;
        match_d  = match_base;
        mis_d    = mis_base;
        fidx_d   = fidx_base;
        fvalid_d = fvalid_base;

        if (accept) begin
            if (idx_base != CntMax) begin
                idx_d = idx_base + CntOne;
            end
            if (cmp_eq) begin
                if (match_base != CntMax) begin
                    match_d = match_base + CntOne;
                end
            end else begin
                if (mis_base != CntMax) begin
                    mis_d = mis_base + CntOne;
                end
                if (!fvalid_base) begin
                    fidx_d   = idx_base;
                    fvalid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            aeqb_q   <= 1'b0;
            altb_q   <= 1'b0;
            agtb_q   <= 1'b0;
            idx_q    <= CntZero;
            match_q  <= CntZero;
            mis_q    <= CntZero;
            fidx_q   <= CntZero;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            aeqb_q   <= aeqb_d;
            altb_q   <= altb_d;
            agtb_q   <= agtb_d;
            idx_q    <= idx_d;
            match_q  <= match_d;
            mis_q    <= mis_d;
            fidx_q   <= fidx_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid;
    assign s.aeqb      = aeqb_q;
    assign s.altb      = altb_q;
    assign s.agtb      = agtb_q;

    assign match_cnt       = match_q;
    assign mismatch_cnt    = mis_q;
    assign first_mis_idx   = fidx_q;
    assign first_mis_valid = fvalid_q;

endmodule

// File: tb/tb_eqn_cmp_stream.sv
// Directed bench for eqn_cmp_stream: unsigned, signed and narrow-counter instances share
// one stimulus stream; expectations are hand-computed constants.
module tb_eqn_cmp_stream;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_valid;
    logic       out_ready;

    int checks;
    int failures;

    // Flag encoding {altb, aeqb, agtb}
    localparam logic [2:0] FlEq   = 3'b010;
    localparam logic [2:0] FlLt   = 3'b100;
    localparam logic [2:0] FlGt   = 3'b001;
    localparam logic [2:0] FlNone = 3'b000;

    eqn_cmp_stream_if #(.WIDTH(2)) if_u ();
    eqn_cmp_stream_if #(.WIDTH(2)) if_s ();
    eqn_cmp_stream_if #(.WIDTH(2)) if_c ();

    assign if_u.a = a;  assign if_u.b = b;
    assign if_u.in_valid = in_valid;  assign if_u.out_ready = out_ready;
    assign if_s.a = a;  assign if_s.b = b;
    assign if_s.in_valid = in_valid;  assign if_s.out_ready = out_ready;
    assign if_c.a = a;  assign if_c.b = b;
    assign if_c.in_valid = in_valid;  assign if_c.out_ready = out_ready;

    logic [15:0] u_match, u_mis, u_fidx;
    logic        u_fval;
    logic [15:0] s_match, s_mis, s_fidx;
    logic        s_fval;
    logic [1:0]  c_match, c_mis, c_fidx;
    logic        c_fval;

    eqn_cmp_stream #(.WIDTH(2), .SIGNED(0), .CNT_WIDTH(16)) u_uns (
        .clk(clk), .rst(rst), .clear(clear), .s(if_u.slave),
        .match_cnt(u_match), .mismatch_cnt(u_mis),
        .first_mis_idx(u_fidx), .first_mis_valid(u_fval)
    );

    eqn_cmp_stream #(.WIDTH(2), .SIGNED(1), .CNT_WIDTH(16)) u_sgn (
        .clk(clk), .rst(rst), .clear(clear), .s(if_s.slave),
        .match_cnt(s_match), .mismatch_cnt(s_mis),
        .first_mis_idx(s_fidx), .first_mis_valid(s_fval)
    );

    eqn_cmp_stream #(.WIDTH(2), .SIGNED(0), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .s(if_c.slave),
        .match_cnt(c_match), .mismatch_cnt(c_mis),
        .first_mis_idx(c_fidx), .first_mis_valid(c_fval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] va, input logic [1:0] vb, input logic v);
        a        = va;
        b        = vb;
        in_valid = v;
    endtask

    logic [1:0] vec_a [7];
    logic [1:0] vec_b [7];
    logic [2:0] exp_u [7];
    logic [2:0] exp_s [7];

    initial begin
        checks    = 0;
        failures  = 0;
        vec_a = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        vec_b = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
        exp_u = '{FlEq, FlGt, FlLt, FlEq, FlGt, FlEq, FlGt};
        exp_s = '{FlEq, FlGt, FlGt, FlEq, FlLt, FlEq, FlLt};

        rst       = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", {31'd0, if_u.out_valid}, 32'd0);
        check("rst_flags", {29'd0, if_u.altb, if_u.aeqb, if_u.agtb}, {29'd0, FlNone});
        check("rst_match", {16'd0, u_match}, 32'd0);
        check("rst_mis", {16'd0, u_mis}, 32'd0);
        check("rst_fidx", {16'd0, u_fidx}, 32'd0);
        check("rst_fval", {31'd0, u_fval}, 32'd0);
        check("rst_in_ready", {31'd0, if_u.in_ready}, 32'd1);

        // eq2 vectors back-to-back, unsigned and signed side by side
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vec_a[i], vec_b[i], 1'b1);
            tick();
            check($sformatf("uns_flags_%0d", i),
                  {29'd0, if_u.altb, if_u.aeqb, if_u.agtb}, {29'd0, exp_u[i]});
            check($sformatf("sgn_flags_%0d", i),
                  {29'd0, if_s.altb, if_s.aeqb, if_s.agtb}, {29'd0, exp_s[i]});
            check($sformatf("uns_ov_%0d", i), {31'd0, if_u.out_valid}, 32'd1);
        end
        drive(2'b00, 2'b00, 1'b0);
        check("eq2_u_match", {16'd0, u_match}, 32'd3);
        check("eq2_u_mis", {16'd0, u_mis}, 32'd4);
        check("eq2_u_fidx", {16'd0, u_fidx}, 32'd1);
        check("eq2_u_fval", {31'd0, u_fval}, 32'd1);
        check("eq2_s_match", {16'd0, s_match}, 32'd3);
        check("eq2_s_mis", {16'd0, s_mis}, 32'd4);
        check("eq2_s_fidx", {16'd0, s_fidx}, 32'd1);
        check("eq2_c_mis_sat", {30'd0, c_mis}, 32'd3);
        tick();
        check("drain_out_valid", {31'd0, if_u.out_valid}, 32'd0);

        // Backpressure: one accept, then hold for the rest of the window
        out_ready = 1'b0;
        drive(2'b01, 2'b11, 1'b1);
        tick();
        check("bp_accept_ov", {31'd0, if_u.out_valid}, 32'd1);
        check("bp_in_ready", {31'd0, if_u.in_ready}, 32'd0);
        drive(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp_hold_flags_%0d", i),
                  {29'd0, if_u.altb, if_u.aeqb, if_u.agtb}, {29'd0, FlLt});
            check($sformatf("bp_hold_rdy_%0d", i), {31'd0, if_u.in_ready}, 32'd0);
        end
        check("bp_mis", {16'd0, u_mis}, 32'd5);
        check("bp_match", {16'd0, u_match}, 32'd3);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'd0, if_u.in_ready}, 32'd1);
        tick();
        check("bp_resume0_flags", {29'd0, if_u.altb, if_u.aeqb, if_u.agtb}, {29'd0, FlEq});
        check("bp_resume0_match", {16'd0, u_match}, 32'd4);
        drive(2'b10, 2'b00, 1'b1);
        tick();
        check("bp_resume1_flags", {29'd0, if_u.altb, if_u.aeqb, if_u.agtb}, {29'd0, FlGt});
        check("bp_resume1_mis", {16'd0, u_mis}, 32'd6);
        drive(2'b00, 2'b00, 1'b0);
        tick();

        // Saturation on the 2-bit-counter instance
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_c_match", {30'd0, c_match}, 32'd0);
        check("clr_u_fval", {31'd0, u_fval}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, 2'b01, 1'b1);
            tick();
        end
        check("sat_c_match", {30'd0, c_match}, 32'd3);
        check("sat_u_match", {16'd0, u_match}, 32'd6);
        drive(2'b00, 2'b01, 1'b1);
        tick();
        check("sat_c_fidx", {30'd0, c_fidx}, 32'd3);
        check("sat_c_fval", {31'd0, c_fval}, 32'd1);
        check("sat_c_mis", {30'd0, c_mis}, 32'd1);
        check("sat_u_fidx", {16'd0, u_fidx}, 32'd6);
        drive(2'b00, 2'b00, 1'b0);

        // Clear coincident with an accepted mismatch after 4 prior pairs
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(2'b00, 2'b00, 1'b1); tick();
        drive(2'b01, 2'b00, 1'b1); tick();
        drive(2'b10, 2'b10, 1'b1); tick();
        drive(2'b11, 2'b11, 1'b1); tick();
        check("pre_clr_fidx", {16'd0, u_fidx}, 32'd1);
        drive(2'b00, 2'b11, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        check("cc_match", {16'd0, u_match}, 32'd0);
        check("cc_mis", {16'd0, u_mis}, 32'd1);
        check("cc_fidx", {16'd0, u_fidx}, 32'd0);
        check("cc_fval", {31'd0, u_fval}, 32'd1);
        check("cc_c_mis", {30'd0, c_mis}, 32'd1);

        // Reset while a result is stalled downstream
        out_ready = 1'b0;
        drive(2'b11, 2'b00, 1'b1);
        tick();
        check("mr_pre_ov", {31'd0, if_u.out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("mr_ov", {31'd0, if_u.out_valid}, 32'd0);
        check("mr_flags", {29'd0, if_u.altb, if_u.aeqb, if_u.agtb}, {29'd0, FlNone});
        check("mr_match", {16'd0, u_match}, 32'd0);
        check("mr_mis", {16'd0, u_mis}, 32'd0);
        check("mr_fval", {31'd0, u_fval}, 32'd0);
        check("mr_c_fidx", {30'd0, c_fidx}, 32'd0);
        rst = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        #1;
        check("mr_in_ready", {31'd0, if_u.in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eqn_cmp_stream.md
# eqn_cmp_stream

Parametrised, registered successor to the 2-bit equality comparator. Compares two WIDTH-bit operand streams word by word behind a valid/ready handshake. Produces registered equal, less-than and greater-than flags with selectable signed or unsigned magnitude. Keeps saturating match and mismatch statistics and captures the index of the first mismatching word, for use as a checker stage between datapath blocks.

## Interface
- WIDTH, 8: operand width in bits; legal range ≥ 1.
- SIGNED, 0: 0 = unsigned magnitude compare; 1 = two's-complement compare.
- CNT_WIDTH, 16: width of the statistics counters and the index register; legal range ≥ 2.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  synchronous clear of statistics and index; does not touch the output register.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_valid  in  1  a/b pair presented.
- in_ready  out  1  block can accept a pair this cycle.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- aeqb  out  1  registered a == b.
- altb  out  1  registered a < b, per SIGNED.
- agtb  out  1  registered a > b, per SIGNED.
- match_cnt  out  CNT_WIDTH  count of accepted pairs with a == b; saturating.
- mismatch_cnt  out  CNT_WIDTH  count of accepted pairs with a != b; saturating.
- first_mis_idx  out  CNT_WIDTH  index of the first accepted mismatching pair.
- first_mis_valid  out  1  first_mis_idx holds a capture.

## Operation
- Accept event: in_valid && in_ready.
- in_ready = !out_valid || out_ready, combinational. This is a single-entry pipeline register with no skid buffer.
- Output register states:
  - EMPTY (out_valid=0): accept → FULL.
  - FULL (out_valid=1):
    - out_ready && accept → stays FULL with new result.
    - out_ready && !accept → EMPTY.
    - !out_ready → hold; aeqb, altb and agtb are stable.
- Flags are one-hot: exactly one of aeqb, altb, agtb is 1 while out_valid=1.
- Compare semantics:
  - SIGNED=1 compares a and b as signed WIDTH-bit values. Example with WIDTH=2: 2'b11 (−1) < 2'b01.
  - SIGNED=0 compares them as unsigned. Example: 2'b11 > 2'b01.
- Index register idx counts accepted pairs since reset or clear. It starts at 0, increments on each accept, and saturates at 2^CNT_WIDTH−1.
- On accept:
  - a == b: match_cnt += 1.
  - a != b: mismatch_cnt += 1.
  - Both counters saturate at all-ones and never wrap.
- First-mismatch capture: on an accepted mismatch with first_mis_valid=0, set first_mis_idx = current idx (pre-increment value) and first_mis_valid = 1. Later mismatches do not update the capture.
- clear (rst=0):
  - Zeroes idx, match_cnt, mismatch_cnt, first_mis_idx and first_mis_valid.
  - If an accept occurs in the same cycle, clear is applied first. The accepted pair is counted as index 0, and its counter and capture updates are applied on top of the zeroed values.
- rst has priority over clear and accept. Any in-flight result is discarded.

## Timing
- Latency: 1 cycle from accept to out_valid=1 with the corresponding flags.
- Throughput: 1 pair per cycle while out_ready=1.
- Statistics latency:
  - match_cnt, mismatch_cnt and first_mis_* reflect an accepted pair in the cycle after the accept, the same cycle its result appears.
  - Statistics do not depend on out_ready.
- Reset values, all outputs after rst:
  - out_valid=0, aeqb=0, altb=0, agtb=0.
  - match_cnt=0, mismatch_cnt=0, first_mis_idx=0, first_mis_valid=0.
  - in_ready=1 once rst is deasserted.
- Reset mid-stream: on the cycle after rst, out_valid=0 and all counters are 0, regardless of pending handshakes.
- Combinational paths: only out_ready → in_ready.

## Test plan
- WIDTH=2, SIGNED=0, out_ready=1: drive the eq2 vectors (00/00, 01/00, 01/11, 10/10, 10/00, 11/11, 11/01) back-to-back.
  - Flags one cycle later: eq, gt, lt, eq, gt, eq, gt.
  - Final state: match_cnt=3, mismatch_cnt=4, first_mis_idx=1, first_mis_valid=1.
- Same vectors with SIGNED=1:
  - 01/11 → agtb.
  - 10/00 → altb.
  - 11/01 → altb.
  - Counters are identical to the unsigned run.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1.
  - One pair is accepted, then in_ready=0.
  - Flags hold stable.
  - The counters advance by exactly 1.
  - Releasing out_ready resumes 1 pair per cycle.
- Saturation, CNT_WIDTH=2: 6 equal pairs → match_cnt=3 and idx saturated. A following mismatch → first_mis_idx=3.
- clear coincident with an accepted mismatch after 4 prior pairs → next cycle match_cnt=0, mismatch_cnt=1, first_mis_idx=0, first_mis_valid=1.
- rst asserted while out_valid=1 and out_ready=0 → next cycle all outputs are at their reset values and in_ready=1 after rst deasserts.
